// File: rtl/cpu_pkg.sv
// Register-file geometry and writeback source IDs shared by the core's
// writeback path and future bypass logic.
package cpu_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    // Round-robin tie-break: the source not granted most recently wins.
    function automatic src_e tie_winner(input src_e last);
        return (last == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, issue-interlock and regFile write-port signals between
// the execute/memory stages and regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic          alu_valid;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          alu_ready;

    logic          mem_valid;
    logic [AW-1:0] mem_rd;
    logic [DW-1:0] mem_data;
    logic          mem_ready;

    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_stall;
    logic [AW-1:0] qa;
    logic [AW-1:0] qb;
    logic          busy_a;
    logic          busy_b;

    logic          wb_we;
    logic [AW-1:0] wb_rw;
    logic [DW-1:0] wb_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output iss_valid, iss_rd, qa, qb,
        input  iss_stall, busy_a, busy_b,
        input  wb_we, wb_rw, wb_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  iss_valid, iss_rd, qa, qb,
        output iss_stall, busy_a, busy_b,
        output wb_we, wb_rw, wb_data
    );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Pending-write scoreboard: one bit per register with an in-flight write,
// looked up combinationally for RAW (qa/qb) and WAW (iss_rd) interlocks.
module wb_scoreboard
    import cpu_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iss_valid_i,
    input  logic [AW-1:0] iss_rd_i,
    input  logic          clr_en_i,
    input  logic [AW-1:0] clr_idx_i,
    input  logic [AW-1:0] qa_i,
    input  logic [AW-1:0] qb_i,
    output logic          iss_stall_o,
    output logic          busy_a_o,
    output logic          busy_b_o
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic            set_en;

    assign iss_stall_o = pending_q[iss_rd_i];
    assign busy_a_o    = pending_q[qa_i];
    assign busy_b_o    = pending_q[qb_i];

    assign set_en = iss_valid_i && !pending_q[iss_rd_i] && (iss_rd_i != '0);

    // Set is applied after clear so a new owner survives a same-edge retire.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_idx_i] = 1'b0;
        end
        if (set_en) begin
            pending_d[iss_rd_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the regFile write port between ALU and load
// writeback, with registered write-port outputs and a pending-write scoreboard.
//
// state (last_q) | meaning
// SRC_ALU        | ALU granted most recently; MEM wins the next tie
// SRC_MEM        | MEM granted most recently; ALU wins the next tie
module regfile_wb_arbiter
    import cpu_pkg::*;
#(
    parameter int DW = REG_DW,
    parameter int AW = REG_AW
) (
    input logic                 clk,
    input logic                 rst,
    regfile_wb_arbiter_if.slave bus
);

    src_e          last_q;
    src_e          last_d;
    logic          wb_we_q;
    logic          wb_we_d;
    logic [AW-1:0] wb_rw_q;
    logic [AW-1:0] wb_rw_d;
    logic [DW-1:0] wb_data_q;
    logic [DW-1:0] wb_data_d;

    logic          alu_gnt;
    logic          mem_gnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= SRC_ALU;
            wb_we_q   <= 1'b0;
            wb_rw_q   <= '0;
            wb_data_q <= '0;
        end else begin
            last_q    <= last_d;
            wb_we_q   <= wb_we_d;
            wb_rw_q   <= wb_rw_d;
            wb_data_q <= wb_data_d;
        end
    end

    // Grants are a pure function of the valids and last_q; a granted valid
    // is by definition a handshake, so the winner is captured unconditionally.
    always_comb begin
        last_d    = last_q;
        wb_we_d   = 1'b0;
        wb_rw_d   = wb_rw_q;
        wb_data_d = wb_data_q;
        if (mem_gnt) begin
            last_d    = SRC_MEM;
            wb_rw_d   = bus.mem_rd;
            wb_data_d = bus.mem_data;
            wb_we_d   = (bus.mem_rd != REG_ZERO);
        end else if (alu_gnt) begin
            last_d    = SRC_ALU;
            wb_rw_d   = bus.alu_rd;
            wb_data_d = bus.alu_data;
            wb_we_d   = (bus.alu_rd != REG_ZERO);
        end
    end

    always_comb begin
        alu_gnt = 1'b0;
        mem_gnt = 1'b0;
        if (bus.alu_valid && bus.mem_valid) begin
            if (tie_winner(last_q) == SRC_MEM) begin
                mem_gnt = 1'b1;
            end else begin
                alu_gnt = 1'b1;
            end
        end else begin
            alu_gnt = bus.alu_valid;
            mem_gnt = bus.mem_valid;
        end
    end

    assign bus.alu_ready = alu_gnt;
    assign bus.mem_ready = mem_gnt;
    assign bus.wb_we     = wb_we_q;
    assign bus.wb_rw     = wb_rw_q;
    assign bus.wb_data   = wb_data_q;

    wb_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .iss_valid_i (bus.iss_valid),
        .iss_rd_i    (bus.iss_rd),
        .clr_en_i    (wb_we_q),
        .clr_idx_i   (wb_rw_q),
        .qa_i        (bus.qa),
        .qb_i        (bus.qb),
        .iss_stall_o (bus.iss_stall),
        .busy_a_o    (bus.busy_a),
        .busy_b_o    (bus.busy_b)
    );

endmodule
